// File: rtl/mult_div_pkg.sv
`default_nettype none
// ============================================================================
// mult_div_pkg : shared constants and state encoding for mult_div_sequencer
// Rev 1.0
// ============================================================================
package mult_div_pkg;

   localparam int   DEFAULT_WIDTH = 32;
   localparam logic MD_MULT       = 1'b0;
   localparam logic MD_DIV        = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// mult_div_sequencer : iterative signed MULT/DIV unit owning the HI/LO pair
// Rev 1.0
// ============================================================================
module mult_div_sequencer
   import mult_div_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             md_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W      = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_op;
   logic               r_sign_a;
   logic               r_sign_b;
   logic [WIDTH-1:0]   r_mag_m;
   logic [WIDTH-1:0]   r_acc;
   logic [WIDTH-1:0]   r_q;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_busy;
   logic               r_done;
   logic               r_div0;

   logic               w_div0_req;
   logic               w_cnt_last;
   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH-1:0]   w_sub;
   logic               w_fits;
   logic [2*WIDTH-1:0] w_prod;

   function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] f_neg_if(input logic neg, input logic [WIDTH-1:0] v);
      return neg ? -v : v;
   endfunction

   // r_q holds the multiplier (MULT) or the dividend being consumed MSB-first (DIV)
   always_comb begin
      w_div0_req  = (md_op == MD_DIV) && (src_b == '0);
      w_cnt_last  = (r_cnt == C_CNT_LAST);
      w_sum       = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mag_m} : '0);
      w_shift     = {r_acc, r_q[WIDTH-1]};
      w_fits      = (w_shift >= {1'b0, r_mag_m});
      w_sub       = w_shift[WIDTH-1:0] - r_mag_m;
      w_prod      = {r_acc, r_q};
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (start && !w_div0_req) w_state_nxt = ST_RUN;
         ST_RUN:  if (w_cnt_last)           w_state_nxt = ST_FIX;
         ST_FIX:                            w_state_nxt = ST_IDLE;
         default:                           w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt    <= '0;
         r_op     <= MD_MULT;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_mag_m  <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_div0   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_div0 <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (w_div0_req) begin
                     r_done <= 1'b1;
                     r_div0 <= 1'b1;
                  end else begin
                     r_op     <= md_op;
                     r_sign_a <= src_a[WIDTH-1];
                     r_sign_b <= src_b[WIDTH-1];
                     r_acc    <= '0;
                     r_cnt    <= '0;
                     r_busy   <= 1'b1;
                     if (md_op == MD_MULT) begin
                        r_q     <= f_abs(src_b);
                        r_mag_m <= f_abs(src_a);
                     end else begin
                        r_q     <= f_abs(src_a);
                        r_mag_m <= f_abs(src_b);
                     end
                  end
               end
            end
            ST_RUN: begin
               r_cnt <= r_cnt + C_CNT_ONE;
               if (r_op == MD_MULT) begin
                  r_acc <= w_sum[WIDTH:1];
                  r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
               end else begin
                  r_acc <= w_fits ? w_sub : w_shift[WIDTH-1:0];
                  r_q   <= {r_q[WIDTH-2:0], w_fits};
               end
            end
            ST_FIX: begin
               // Remainder takes the dividend's sign (truncating division)
               if (r_op == MD_MULT) begin
                  {r_hi, r_lo} <= (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
               end else begin
                  r_lo <= f_neg_if(r_sign_a ^ r_sign_b, r_q);
                  r_hi <= f_neg_if(r_sign_a, r_acc);
               end
               r_busy <= 1'b0;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign div0 = r_div0;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mult_div_sequencer : scoreboard bench with an arithmetic reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mult_div_sequencer;
   import mult_div_pkg::*;

   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         md_op = 1'b0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic         busy;
   logic         done;
   logic         div0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   mult_div_sequencer #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .md_op (md_op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .done  (done),
      .div0  (div0),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      int           edge_no;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         d0;
   } exp_t;

   exp_t         sb[$];
   exp_t         e_mon;
   int           busy_lo = -100;
   int           busy_hi = -100;
   logic [W-1:0] mdl_hi  = '0;
   logic [W-1:0] mdl_lo  = '0;
   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;
   int           checks  = 0;
   int           errors  = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (edge %0d)", name, act, exp, cyc);
      end
   endfunction

   // Architectural result from plain signed arithmetic; / and % truncate toward zero
   task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      int     k;
      exp_t   e;
      longint sa, sbv, p;
      start = 1'b1; md_op = op; src_a = a; src_b = b;
      k = cyc + 1;
      if (k > busy_hi + 1) begin
         sa  = longint'($signed(a));
         sbv = longint'($signed(b));
         e.d0 = 1'b0;
         if (op == MD_DIV && sbv == 0) begin
            e.d0 = 1'b1; e.hi = mdl_hi; e.lo = mdl_lo; e.edge_no = k;
         end else begin
            if (op == MD_MULT) begin
               p = sa * sbv;
               e.hi = p[63:32]; e.lo = p[31:0];
            end else begin
               e.lo = W'(sa / sbv); e.hi = W'(sa % sbv);
            end
            e.edge_no = k + W + 1;
            busy_lo = k; busy_hi = k + W;
         end
         mdl_hi = e.hi; mdl_lo = e.lo;
         sb.push_back(e);
      end
      @(negedge clock);
      start = 1'b0; md_op = 1'($urandom); src_a = $urandom; src_b = $urandom;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done !== 1'b1 && n < 60) begin
         @(negedge clock);
         n++;
      end
      chk(name, {63'd0, done}, 64'd1);
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      sb.delete();
      busy_lo = -100; busy_hi = -100;
      mdl_hi = '0; mdl_lo = '0; last_hi = '0; last_lo = '0;
      @(posedge clock); #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Monitor: busy window every cycle, scoreboard pop on done, HI/LO hold otherwise
   always @(negedge clock) begin
      if (!reset) begin
         chk("busy", {63'd0, busy}, {63'd0, (cyc >= busy_lo && cyc <= busy_hi)});
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_done actual=1 expected=0 (edge %0d)", cyc);
            end else begin
               e_mon = sb.pop_front();
               chk("done_edge", 64'(cyc), 64'(e_mon.edge_no));
               chk("hi", {32'd0, hi}, {32'd0, e_mon.hi});
               chk("lo", {32'd0, lo}, {32'd0, e_mon.lo});
               chk("div0", {63'd0, div0}, {63'd0, e_mon.d0});
               last_hi = e_mon.hi; last_lo = e_mon.lo;
            end
         end else begin
            chk("hold_hi", {32'd0, hi}, {32'd0, last_hi});
            chk("hold_lo", {32'd0, lo}, {32'd0, last_lo});
            chk("div0_idle", {63'd0, div0}, 64'd0);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic         op;
      logic [W-1:0] a, b;
      int           sel;
      repeat (3) @(posedge clock);
      #1;
      chk("init_busy", {63'd0, busy}, 64'd0);
      chk("init_done", {63'd0, done}, 64'd0);
      chk("init_div0", {63'd0, div0}, 64'd0);
      chk("init_hi", {32'd0, hi}, 64'd0);
      chk("init_lo", {32'd0, lo}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      issue(MD_MULT, 32'd7, 32'hFFFF_FFFD);
      wait_done("t1_done");
      chk("t1_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      chk("t1_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);

      issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done("t2a_done");
      chk("t2a_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
      chk("t2a_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      issue(MD_DIV, 32'd100, 32'd7);
      wait_done("t2b_done");
      chk("t2b_lo", {32'd0, lo}, 64'd14);
      chk("t2b_hi", {32'd0, hi}, 64'd2);

      issue(MD_DIV, 32'h0000_2211, 32'h0000_0100);
      wait_done("t3_prep_done");
      issue(MD_DIV, 32'd5, 32'd0);
      wait_done("t3_done");
      chk("t3_div0", {63'd0, div0}, 64'd1);
      chk("t3_hi", {32'd0, hi}, 64'h11);
      chk("t3_lo", {32'd0, lo}, 64'h22);

      issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("t4a_done");
      chk("t4a_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
      chk("t4a_hi", {32'd0, hi}, 64'd0);
      issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
      wait_done("t4b_done");
      chk("t4b_hi", {32'd0, hi}, 64'h0000_0000_4000_0000);
      chk("t4b_lo", {32'd0, lo}, 64'd0);

      issue(MD_MULT, 32'd3, 32'd4);
      repeat (8) @(negedge clock);
      issue(MD_DIV, 32'd9, 32'd3);
      wait_done("t5a_done");
      chk("t5a_lo", {32'd0, lo}, 64'd12);
      issue(MD_DIV, 32'd9, 32'd3);
      wait_done("t5b_done");
      chk("t5b_lo", {32'd0, lo}, 64'd3);
      chk("t5b_hi", {32'd0, hi}, 64'd0);

      issue(MD_MULT, 32'd5, 32'd5);
      repeat (13) @(negedge clock);
      apply_reset();
      @(negedge clock);
      issue(MD_MULT, 32'd6, 32'hFFFF_FFF9);
      wait_done("t6_done");
      chk("t6_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFD6);

      for (int i = 0; i < 40; i++) begin
         op  = 1'($urandom);
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 7);
         if (sel == 0)      b = '0;
         else if (sel == 1) b = 32'($urandom_range(1, 300));
         else if (sel == 2) b = -32'($urandom_range(1, 300));
         else if (sel == 3) a = 32'h8000_0000;
         else if (sel == 4) a = 32'($urandom_range(0, 1000));
         issue(op, a, b);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 20)) @(negedge clock);
            issue(1'($urandom), $urandom, $urandom);
         end
         wait_done("rnd_done");
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end

      repeat (40) @(negedge clock);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
